// File: rtl/piezo_melody_player.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : piezo_melody_player
// Description : Table-driven melody player for a piezo buzzer. A rising edge
//               on trig with a non-zero snd_mode latches the mode and plays
//               that melody from a fixed ROM, note by note, as a square wave.
//               Optional build macro SND_PREEMPT_EN: a valid request arriving
//               during playback restarts playback with the new mode.
// Ports       : clk_1mhz  - system clock
//               rst       - asynchronous active-low reset
//               snd_mode  - melody select (1..7, 0 = none)
//               trig      - play request, rising edge is the request
//               playing   - high while a melody is in progress
//               piezo_out - square-wave drive to the piezo
// Revision    : 1.0 - initial release
// ============================================================================
module piezo_melody_player #(
    parameter int CLK_HZ      = 1000000,
    parameter int TICK_CYCLES = 10000,
    parameter int MAX_NOTES   = 8
) (
    input  logic       clk_1mhz,
    input  logic       rst,
    input  logic [2:0] snd_mode,
    input  logic       trig,
    output logic       playing,
    output logic       piezo_out
);

    localparam int c_TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int c_IDX_W  = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
    // Half-period table is in 1 MHz cycles; scale by the integer clock ratio.
    localparam int unsigned c_CLK_SCALE = (CLK_HZ / 1000000 < 1) ? 1 : (CLK_HZ / 1000000);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_PLAY = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic                r_trig_prev;
    logic [2:0]          r_mode;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [5:0]          r_unit_cnt;
    logic [15:0]         r_tone_cnt;
    logic                r_piezo;

    logic                w_trig_req;
    logic                w_start;
    logic [2:0]          w_idx3;
    logic [5:0]          w_sel;
    logic [3:0]          w_tone;
    logic [5:0]          w_ticks;
    logic [2:0]          w_last3;
    logic [15:0]         w_half_base;
    logic [15:0]         w_half;
    logic                w_tick_done;
    logic                w_unit_last;
    logic                w_note_done;
    logic                w_last_note;

    assign w_trig_req = trig && !r_trig_prev && (snd_mode != 3'd0);

`ifdef SND_PREEMPT_EN
    assign w_start = w_trig_req;
`else
    assign w_start = w_trig_req && (r_state == c_ST_IDLE);
`endif

    // ROM address: octal digit pair {mode, note index}.
    assign w_idx3 = 3'(r_idx);
    assign w_sel  = {r_mode, w_idx3};

    always_comb begin
        w_tone  = 4'd0;
        w_ticks = 6'd0;
        case (w_sel)
            6'o10: begin w_tone = 4'd6;  w_ticks = 6'd10; end
            6'o20: begin w_tone = 4'd11; w_ticks = 6'd30; end
            6'o30: begin w_tone = 4'd8;  w_ticks = 6'd5;  end
            6'o31: begin w_tone = 4'd10; w_ticks = 6'd5;  end
            6'o40: begin w_tone = 4'd1;  w_ticks = 6'd15; end
            6'o50: begin w_tone = 4'd8;  w_ticks = 6'd10; end
            6'o51: begin w_tone = 4'd9;  w_ticks = 6'd10; end
            6'o52: begin w_tone = 4'd10; w_ticks = 6'd10; end
            6'o53: begin w_tone = 4'd11; w_ticks = 6'd20; end
            6'o60: begin w_tone = 4'd5;  w_ticks = 6'd15; end
            6'o61: begin w_tone = 4'd3;  w_ticks = 6'd15; end
            6'o62: begin w_tone = 4'd2;  w_ticks = 6'd15; end
            6'o63: begin w_tone = 4'd1;  w_ticks = 6'd30; end
            6'o70: begin w_tone = 4'd8;  w_ticks = 6'd10; end
            6'o71: begin w_tone = 4'd9;  w_ticks = 6'd10; end
            6'o72: begin w_tone = 4'd10; w_ticks = 6'd10; end
            6'o73: begin w_tone = 4'd11; w_ticks = 6'd10; end
            6'o74: begin w_tone = 4'd10; w_ticks = 6'd10; end
            6'o75: begin w_tone = 4'd11; w_ticks = 6'd30; end
            default: ;
        endcase
    end

    // Index of the final note of each melody.
    always_comb begin
        w_last3 = 3'd0;
        case (r_mode)
            3'd3:    w_last3 = 3'd1;
            3'd5:    w_last3 = 3'd3;
            3'd6:    w_last3 = 3'd3;
            3'd7:    w_last3 = 3'd5;
            default: w_last3 = 3'd0;
        endcase
    end

    always_comb begin
        w_half_base = 16'd0;
        case (w_tone)
            4'd1:    w_half_base = 16'd1911;
            4'd2:    w_half_base = 16'd1703;
            4'd3:    w_half_base = 16'd1517;
            4'd4:    w_half_base = 16'd1432;
            4'd5:    w_half_base = 16'd1276;
            4'd6:    w_half_base = 16'd1136;
            4'd7:    w_half_base = 16'd1012;
            4'd8:    w_half_base = 16'd956;
            4'd9:    w_half_base = 16'd758;
            4'd10:   w_half_base = 16'd638;
            4'd11:   w_half_base = 16'd478;
            default: w_half_base = 16'd0;
        endcase
    end

    assign w_half      = 16'(w_half_base * c_CLK_SCALE);
    assign w_tick_done = (r_tick_cnt == c_TICK_LAST);
    assign w_unit_last = (r_unit_cnt == (w_ticks - 6'd1));
    assign w_note_done = w_tick_done && w_unit_last;
    assign w_last_note = (w_idx3 == w_last3);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_start) w_state_nxt = c_ST_PLAY;
            c_ST_PLAY: if (w_note_done && w_last_note && !w_start) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_1mhz or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_1mhz or negedge rst) begin
        if (!rst) begin
            r_trig_prev <= 1'b0;
            r_mode      <= 3'd0;
            r_idx       <= '0;
            r_tick_cnt  <= '0;
            r_unit_cnt  <= 6'd0;
            r_tone_cnt  <= 16'd0;
            r_piezo     <= 1'b0;
        end else begin
            r_trig_prev <= trig;
            if (w_start) begin
                r_mode     <= snd_mode;
                r_idx      <= '0;
                r_tick_cnt <= '0;
                r_unit_cnt <= 6'd0;
                r_tone_cnt <= 16'd0;
                r_piezo    <= 1'b0;
            end else if (r_state == c_ST_PLAY) begin
                r_tick_cnt <= w_tick_done ? '0 : r_tick_cnt + c_TICK_W'(1);
                if (w_tick_done) begin
                    r_unit_cnt <= w_unit_last ? 6'd0 : r_unit_cnt + 6'd1;
                end
                // Each note starts low with a fresh half-period count.
                if (w_note_done) begin
                    r_idx      <= w_last_note ? '0 : r_idx + c_IDX_W'(1);
                    r_tone_cnt <= 16'd0;
                    r_piezo    <= 1'b0;
                end else if (w_half == 16'd0) begin
                    r_tone_cnt <= 16'd0;
                    r_piezo    <= 1'b0;
                end else if (r_tone_cnt == (w_half - 16'd1)) begin
                    r_tone_cnt <= 16'd0;
                    r_piezo    <= ~r_piezo;
                end else begin
                    r_tone_cnt <= r_tone_cnt + 16'd1;
                end
            end else begin
                r_tone_cnt <= 16'd0;
                r_piezo    <= 1'b0;
            end
        end
    end

    assign playing   = (r_state == c_ST_PLAY);
    assign piezo_out = r_piezo;

endmodule
`default_nettype wire

// File: tb/tb_piezo_melody_player.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_piezo_melody_player
// Description : Self-checking bench for piezo_melody_player. Each request is
//               turned into a list of expected output transitions (cycle,
//               value) from the melody table; a monitor compares every
//               observed transition of playing/piezo_out with that list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piezo_melody_player;

    localparam int T = 200;   // short tick keeps run time small

    logic       clk_1mhz = 1'b0;
    logic       rst      = 1'b0;
    logic [2:0] snd_mode = 3'd0;
    logic       trig     = 1'b0;
    logic       playing;
    logic       piezo_out;

    piezo_melody_player #(
        .CLK_HZ      (1000000),
        .TICK_CYCLES (T),
        .MAX_NOTES   (8)
    ) u_dut (
        .clk_1mhz  (clk_1mhz),
        .rst       (rst),
        .snd_mode  (snd_mode),
        .trig      (trig),
        .playing   (playing),
        .piezo_out (piezo_out)
    );

    always #5 clk_1mhz = ~clk_1mhz;

    int cyc = 0;   // number of rising edges so far
    always @(posedge clk_1mhz) cyc <= cyc + 1;

    typedef struct {
        int t;
        bit v;
    } evt_t;

    evt_t pl_q[$];
    evt_t pz_q[$];
    int   pl_rd = 0;
    int   pz_rd = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   play_end = -1;
    int   last_n = 0;

    int half_tab[16];
    int mel_len[8];
    int mel_tone[8][6];
    int mel_tk[8][6];

    bit mon_en  = 1'b0;
    bit last_pl = 1'b0;
    bit last_pz = 1'b0;

    task automatic push_pl(input int t, input bit v);
        evt_t e;
        e.t = t; e.v = v;
        pl_q.push_back(e);
    endtask

    task automatic push_pz(input int t, input bit v);
        evt_t e;
        e.t = t; e.v = v;
        pz_q.push_back(e);
    endtask

    // Reference: request accepted at edge n produces playing high over
    // sum(ticks)*T cycles and, per note, toggles every half-period from the
    // note start, strictly before the note end; a high level drops at the end.
    task automatic model_request(input int n, input int mode);
        int s, e, h, lvl;
        if (mode == 0) return;
        if (n <= play_end) begin
`ifdef SND_PREEMPT_EN
            while (pz_q.size() > pz_rd && pz_q[pz_q.size()-1].t >= n) void'(pz_q.pop_back());
            lvl = (pz_q.size() > 0) ? int'(pz_q[pz_q.size()-1].v) : 0;
            if (lvl != 0) push_pz(n, 1'b0);
            while (pl_q.size() > pl_rd && pl_q[pl_q.size()-1].t >= n) void'(pl_q.pop_back());
`else
            return;
`endif
        end else begin
            push_pl(n, 1'b1);
        end
        s = n;
        for (int j = 0; j < mel_len[mode]; j++) begin
            h   = half_tab[mel_tone[mode][j]];
            e   = s + mel_tk[mode][j] * T;
            lvl = 0;
            if (h > 0) begin
                for (int t = s + h; t < e; t += h) begin
                    lvl = 1 - lvl;
                    push_pz(t, lvl[0]);
                end
            end
            if (lvl != 0) push_pz(e, 1'b0);
            s = e;
        end
        play_end = s;
        push_pl(s, 1'b0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic trig_req(input int mode, input int hold);
        @(negedge clk_1mhz);
        snd_mode = 3'(mode);
        trig     = 1'b1;
        last_n   = cyc + 1;
        model_request(cyc + 1, mode);
        repeat (hold) begin
            @(negedge clk_1mhz);
            snd_mode = 3'($urandom_range(0, 7));
        end
        trig = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(negedge clk_1mhz);
            snd_mode = 3'($urandom_range(0, 7));
        end
    endtask

    always @(posedge clk_1mhz) begin
        #1;
        if (mon_en) begin
            if (playing !== last_pl) begin
                n_cmp++;
                if (pl_rd >= pl_q.size()) begin
                    n_bad++;
                    $display("FAIL playing_evt: unexpected change to %b at cycle %0d", playing, cyc);
                end else begin
                    if (pl_q[pl_rd].t != cyc || pl_q[pl_rd].v !== playing) begin
                        n_bad++;
                        $display("FAIL playing_evt: got %b at cycle %0d expected %b at cycle %0d",
                                 playing, cyc, pl_q[pl_rd].v, pl_q[pl_rd].t);
                    end
                    pl_rd++;
                end
                last_pl = playing;
            end
            if (piezo_out !== last_pz) begin
                n_cmp++;
                if (pz_rd >= pz_q.size()) begin
                    n_bad++;
                    $display("FAIL piezo_evt: unexpected change to %b at cycle %0d", piezo_out, cyc);
                end else begin
                    if (pz_q[pz_rd].t != cyc || pz_q[pz_rd].v !== piezo_out) begin
                        n_bad++;
                        $display("FAIL piezo_evt: got %b at cycle %0d expected %b at cycle %0d",
                                 piezo_out, cyc, pz_q[pz_rd].v, pz_q[pz_rd].t);
                    end
                    pz_rd++;
                end
                last_pz = piezo_out;
            end
        end
    end

    initial begin
        int n6;
        half_tab = '{0, 1911, 1703, 1517, 1432, 1276, 1136, 1012, 956, 758, 638, 478, 0, 0, 0, 0};
        mel_len  = '{0, 1, 1, 2, 1, 4, 4, 6};
        mel_tone = '{'{0, 0, 0, 0, 0, 0},    '{6, 0, 0, 0, 0, 0},
                     '{11, 0, 0, 0, 0, 0},   '{8, 10, 0, 0, 0, 0},
                     '{1, 0, 0, 0, 0, 0},    '{8, 9, 10, 11, 0, 0},
                     '{5, 3, 2, 1, 0, 0},    '{8, 9, 10, 11, 10, 11}};
        mel_tk   = '{'{0, 0, 0, 0, 0, 0},    '{10, 0, 0, 0, 0, 0},
                     '{30, 0, 0, 0, 0, 0},   '{5, 5, 0, 0, 0, 0},
                     '{15, 0, 0, 0, 0, 0},   '{10, 10, 10, 20, 0, 0},
                     '{15, 15, 15, 30, 0, 0}, '{10, 10, 10, 10, 10, 30}};

        // Reset state
        repeat (3) @(negedge clk_1mhz);
        chk("reset_playing", int'(playing), 0);
        chk("reset_piezo", int'(piezo_out), 0);
        rst     = 1'b1;
        last_pl = 1'b0;
        last_pz = 1'b0;
        mon_en  = 1'b1;
        repeat (5) @(negedge clk_1mhz);

        // Single-note countdown, one-cycle trig
        trig_req(1, 1);
        wait_until(play_end + 2);

        // Stage clear with trig held high: exactly one melody
        trig_req(5, 50);
        wait_until(play_end + 2);

        // Mode 0 request is ignored
        trig_req(0, 3);
        wait_until(cyc + 100);
        chk("mode0_playing", int'(playing), 0);
        chk("mode0_piezo", int'(piezo_out), 0);

        // Game over, then a hit request 20 ticks in
        trig_req(6, 1);
        n6 = last_n;
        wait_until(n6 + 20 * T - 1);
        trig_req(3, 1);
        wait_until(play_end + 2);

        // Back-to-back: new request one cycle after playing falls
        trig_req(3, 2);
        wait_until(play_end);
        trig_req(2, 1);
        wait_until(play_end + 2);

        // Randomized requests, some arriving mid-melody
        for (int i = 0; i < 3; i++) begin
            trig_req($urandom_range(0, 4), $urandom_range(1, 20));
            if ($urandom_range(0, 1) == 1) begin
                wait_until(cyc + $urandom_range(10, 600));
                trig_req($urandom_range(0, 4), 1);
            end
            wait_until(play_end + $urandom_range(0, 3));
        end
        wait_until(play_end + 2);
        chk("pl_events_consumed", pl_rd, pl_q.size());
        chk("pz_events_consumed", pz_rd, pz_q.size());

        // Asynchronous reset in the middle of a melody
        trig_req(7, 1);
        wait_until(cyc + 3000);
        @(negedge clk_1mhz);
        #2;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        chk("async_rst_playing", int'(playing), 0);
        chk("async_rst_piezo", int'(piezo_out), 0);
        pl_q.delete();
        pz_q.delete();
        pl_rd    = 0;
        pz_rd    = 0;
        play_end = -1;
        repeat (3) @(negedge clk_1mhz);
        rst     = 1'b1;
        last_pl = 1'b0;
        last_pz = 1'b0;
        mon_en  = 1'b1;
        wait_until(cyc + 200);
        chk("post_rst_playing", int'(playing), 0);
        chk("post_rst_piezo", int'(piezo_out), 0);

        // Normal operation after reset release
        trig_req(4, 1);
        wait_until(play_end + 2);
        chk("final_pl_events_consumed", pl_rd, pl_q.size());
        chk("final_pz_events_consumed", pz_rd, pz_q.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piezo_melody_player.md
Name: piezo_melody_player

Overview:
- Sound back-end directly downstream of the game main FSM; consumes its `snd_mode`/`trig` request pair and reports `playing` back to it.
- Holds a fixed melody ROM (one melody per mode) and a sequencer that steps through notes.
- A square-wave tone generator drives the piezo buzzer.
- Replaces the ad-hoc sound manager with a table-driven, fixed-latency player.

Parameters:
- CLK_HZ, 1000000, input clock frequency in Hz.
- TICK_CYCLES, 10000, clock cycles per duration unit (10 ms at 1 MHz).
- MAX_NOTES, 8, maximum notes per melody; sizes the note index counter.

Ports:
- clk_1mhz  in  1  system clock, 1 MHz.
- rst  in  1  asynchronous active-low reset; all state clears while low.
- snd_mode  in  3  melody select, 1..7; 0 = none.
- trig  in  1  play request; the 0->1 edge is the request.
- playing  out  1  high while a melody is in progress.
- piezo_out  out  1  square-wave drive to the piezo.

Behaviour:
- Reset values: playing=0, piezo_out=0, FSM=IDLE, all counters 0.
- Tone codes (4 bits) map to half-periods in clock cycles:
  - 0 rest (output held 0), 1 C4 1911, 2 D4 1703, 3 E4 1517, 4 F4 1432.
  - 5 G4 1276, 6 A4 1136, 7 B4 1012, 8 C5 956, 9 E5 758.
  - 10 G5 638, 11 C6 478, 12-15 rest.
- Melody ROM, as (tone, ticks) pairs:
  - 1 countdown: (A4,10).
  - 2 start: (C6,30).
  - 3 hit: (C5,5), (G5,5).
  - 4 miss: (C4,15).
  - 5 stage clear: (C5,10), (E5,10), (G5,10), (C6,20).
  - 6 game over: (G4,15), (E4,15), (D4,15), (C4,30).
  - 7 game clear: (C5,10), (E5,10), (G5,10), (C6,10), (G5,10), (C6,30).
- Melody length is stored per mode. Notes are back-to-back with no inter-note gap.
- trig is edge-detected internally from a registered previous value. A held-high trig starts exactly one melody.
- FSM states and transitions:
  - IDLE: on trig edge with snd_mode!=0, latch snd_mode, set note index to 0, go to PLAY. A trig edge with snd_mode=0 is ignored and playing stays 0.
  - PLAY: the tick counter counts TICK_CYCLES per unit. When the current note's ticks expire, advance the note index. After the last note expires, go to IDLE.
- Latency and timing:
  - Trig edge sampled at cycle N: playing=1 from N+1.
  - First piezo toggle occurs half-period cycles after N+1.
  - playing falls on the cycle after the last tick of the last note expires.
  - Total playing time is exactly sum(ticks)*TICK_CYCLES cycles.
- Tone generator:
  - Half-period counter toggles piezo_out on reaching the half-period.
  - Counter and piezo_out are forced to 0 at every note boundary and on rest notes, so each note starts low.
- snd_mode changes during playback have no effect; only the latched mode is used.
- Reset asserted mid-melody clears playing and piezo_out immediately (asynchronously). No resume after reset release.

Optional Feature:
- Macro: SND_PREEMPT_EN.
- Defined: a valid trig edge during PLAY restarts playback with the newly latched snd_mode.
  - Index, tick and tone counters clear; piezo_out is driven 0 for that cycle.
  - playing stays 1 continuously; no low glitch.
- Undefined: trig edges during PLAY are ignored. The current melody finishes, and a new request is accepted only once back in IDLE.

Test Plan:
- Reset low during activity -> playing=0 and piezo_out=0 within the same cycle. After release, both stay 0 until the first trig.
- snd_mode=1, one-cycle trig -> playing high for exactly 100000 cycles. piezo_out toggles every 1136 cycles (period 2272, about 440 Hz), then falls.
- snd_mode=5, trig held high for 50 cycles -> one melody only, playing for 500000 cycles. Half-periods are 956/758/638/478 in successive segments of 100000/100000/100000/200000 cycles.
- snd_mode=0 with trig -> playing never rises and piezo_out stays 0.
- snd_mode=6 playing, then at cycle 200000 a trig with snd_mode=3:
  - With SND_PREEMPT_EN: restarts the hit melody, playing stays continuous and ends 100000 cycles later.
  - Without SND_PREEMPT_EN: the game-over melody runs its full 750000 cycles.
- Back-to-back requests: mode 3 completes, then a trig one cycle after playing falls -> accepted. playing is high again at the next cycle.
